// File: rtl/mem_req_arb_delay.sv
// N-port round-robin memory request arbiter with send/receive interval throttles.
// Define MEM_REQ_ARB_STATS_EN to add per-port request and dropped-response counters.
module mem_req_arb_delay #(
  parameter int p_num_ports       = 2,
  parameter int p_opaq_bits       = 8,
  parameter int p_addr_bits       = 32,
  parameter int p_data_bits       = 32,
  parameter int p_send_intv_delay = 1,
  parameter int p_recv_intv_delay = 1,
  localparam int p_port_bits      = (p_num_ports > 1) ? $clog2(p_num_ports) : 1,
  localparam int p_mopq_bits      = p_port_bits + p_opaq_bits
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [p_num_ports-1:0]             req_val,
  output logic [p_num_ports-1:0]             req_rdy,
  input  logic [p_num_ports-1:0]             req_op,
  input  logic [p_num_ports*p_addr_bits-1:0] req_addr,
  input  logic [p_num_ports*p_data_bits-1:0] req_data,
  input  logic [p_num_ports*p_opaq_bits-1:0] req_opaque,
  output logic                               mem_req_val,
  input  logic                               mem_req_rdy,
  output logic                               mem_req_op,
  output logic [p_addr_bits-1:0]             mem_req_addr,
  output logic [p_data_bits-1:0]             mem_req_data,
  output logic [p_mopq_bits-1:0]             mem_req_opaque,
  input  logic                               mem_resp_val,
  output logic                               mem_resp_rdy,
  input  logic                               mem_resp_op,
  input  logic [p_addr_bits-1:0]             mem_resp_addr,
  input  logic [p_data_bits-1:0]             mem_resp_data,
  input  logic [p_mopq_bits-1:0]             mem_resp_opaque,
  output logic [p_num_ports-1:0]             resp_val,
  input  logic [p_num_ports-1:0]             resp_rdy,
  output logic                               resp_op,
  output logic [p_addr_bits-1:0]             resp_addr,
  output logic [p_data_bits-1:0]             resp_data,
  output logic [p_opaq_bits-1:0]             resp_opaque
`ifdef MEM_REQ_ARB_STATS_EN
  ,
  output logic [p_num_ports*32-1:0]          stat_req_count,
  output logic [31:0]                        stat_drop_count
`endif
);

  localparam int p_send_cnt_bits = (p_send_intv_delay > 1) ? $clog2(p_send_intv_delay) : 1;
  localparam int p_recv_cnt_bits = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay) : 1;
  localparam logic [p_send_cnt_bits-1:0] p_send_reload = p_send_cnt_bits'(p_send_intv_delay - 1);
  localparam logic [p_recv_cnt_bits-1:0] p_recv_reload = p_recv_cnt_bits'(p_recv_intv_delay - 1);
  localparam logic [p_port_bits-1:0]     p_last_port   = p_port_bits'(p_num_ports - 1);

  logic [p_port_bits-1:0]     prio_q, prio_d;
  logic [p_send_cnt_bits-1:0] send_cnt_q, send_cnt_d;
  logic [p_recv_cnt_bits-1:0] recv_cnt_q, recv_cnt_d;

  logic [p_num_ports-1:0] above_s, cand_s, grant_oh_s;
  logic [p_port_bits-1:0] grant_id_s, resp_id_s;
  logic                   grant_found_s, send_ok_s, req_hs_s;
  logic                   recv_ok_s, resp_in_range_s, resp_sel_rdy_s, resp_hs_s;
  logic [p_opaq_bits-1:0] opq_mux_s;

  // Round-robin grant: lowest valid port at or above prio, else wrap to lowest valid port
  always_comb begin
    above_s = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      above_s[i] = req_val[i] & (i >= int'(prio_q));
    end
    cand_s = (|above_s) ? above_s : req_val;
    grant_id_s = '0;
    for (int i = p_num_ports - 1; i >= 0; i--) begin
      grant_id_s = cand_s[i] ? p_port_bits'(i) : grant_id_s;
    end
    grant_found_s = |req_val;
    grant_oh_s = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      grant_oh_s[i] = grant_found_s & (grant_id_s == p_port_bits'(i));
    end
  end

  // Request payload mux from the granted port
  always_comb begin
    mem_req_op   = 1'b0;
    mem_req_addr = '0;
    mem_req_data = '0;
    opq_mux_s    = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      mem_req_op   = mem_req_op | (grant_oh_s[i] & req_op[i]);
      mem_req_addr = mem_req_addr | ({p_addr_bits{grant_oh_s[i]}} & req_addr[i*p_addr_bits +: p_addr_bits]);
      mem_req_data = mem_req_data | ({p_data_bits{grant_oh_s[i]}} & req_data[i*p_data_bits +: p_data_bits]);
      opq_mux_s    = opq_mux_s | ({p_opaq_bits{grant_oh_s[i]}} & req_opaque[i*p_opaq_bits +: p_opaq_bits]);
    end
    mem_req_opaque = {grant_id_s, opq_mux_s};
  end

  // Request handshake, priority pointer and send throttle
  always_comb begin
    send_ok_s   = (send_cnt_q == '0);
    mem_req_val = grant_found_s & send_ok_s;
    req_rdy     = grant_oh_s & {p_num_ports{mem_req_rdy & send_ok_s}};
    req_hs_s    = mem_req_val & mem_req_rdy;
    // A stalled request pins prio to its port so a later arrival cannot steal the grant.
    if (req_hs_s) begin
      prio_d = (grant_id_s == p_last_port) ? '0 : grant_id_s + p_port_bits'(1);
    end else if (mem_req_val) begin
      prio_d = grant_id_s;
    end else begin
      prio_d = prio_q;
    end
    if (req_hs_s) begin
      send_cnt_d = p_send_reload;
    end else if (!send_ok_s) begin
      send_cnt_d = send_cnt_q - p_send_cnt_bits'(1);
    end else begin
      send_cnt_d = send_cnt_q;
    end
  end

  // Response routing by port ID, out-of-range IDs are accepted and dropped
  always_comb begin
    resp_id_s       = mem_resp_opaque[p_mopq_bits-1 -: p_port_bits];
    resp_in_range_s = (int'(resp_id_s) < p_num_ports);
    recv_ok_s       = (recv_cnt_q == '0);
    resp_val        = '0;
    resp_sel_rdy_s  = 1'b0;
    for (int i = 0; i < p_num_ports; i++) begin
      resp_val[i]    = mem_resp_val & recv_ok_s & (resp_id_s == p_port_bits'(i));
      resp_sel_rdy_s = resp_sel_rdy_s | (resp_rdy[i] & (resp_id_s == p_port_bits'(i)));
    end
    mem_resp_rdy = recv_ok_s & (resp_in_range_s ? resp_sel_rdy_s : 1'b1);
    resp_hs_s    = mem_resp_val & mem_resp_rdy;
    resp_op      = mem_resp_op;
    resp_addr    = mem_resp_addr;
    resp_data    = mem_resp_data;
    resp_opaque  = mem_resp_opaque[p_opaq_bits-1:0];
    if (resp_hs_s) begin
      recv_cnt_d = p_recv_reload;
    end else if (!recv_ok_s) begin
      recv_cnt_d = recv_cnt_q - p_recv_cnt_bits'(1);
    end else begin
      recv_cnt_d = recv_cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q     <= '0;
      send_cnt_q <= '0;
      recv_cnt_q <= '0;
    end else begin
      prio_q     <= prio_d;
      send_cnt_q <= send_cnt_d;
      recv_cnt_q <= recv_cnt_d;
    end
  end

`ifdef MEM_REQ_ARB_STATS_EN
  logic [p_num_ports*32-1:0] stat_req_q, stat_req_d;
  logic [31:0]               stat_drop_q, stat_drop_d;

  // Statistics next-state: per-port accepted requests and dropped responses
  always_comb begin
    stat_req_d = stat_req_q;
    for (int i = 0; i < p_num_ports; i++) begin
      stat_req_d[i*32 +: 32] = stat_req_q[i*32 +: 32] + {31'd0, req_val[i] & req_rdy[i]};
    end
    stat_drop_d = stat_drop_q + {31'd0, resp_hs_s & ~resp_in_range_s};
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_req_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_req_q  <= stat_req_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_req_count  = stat_req_q;
  assign stat_drop_count = stat_drop_q;
`endif

endmodule

// File: tb/tb_mem_req_arb_delay.sv
// Bench for mem_req_arb_delay: a 2-port full-rate instance and a 3-port instance with
// interval delays of 3, driven by directed scenarios and random traffic against a reference model.
module tb_mem_req_arb_delay;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus, index 0 = instance a (2 ports), 1 = instance b (3 ports)
  logic [2:0]  s_req_val [2];
  logic [2:0]  s_req_op  [2];
  logic [2:0]  s_resp_rdy[2];
  logic [15:0] s_addr[2][3];
  logic [15:0] s_data[2][3];
  logic [7:0]  s_opq [2][3];
  logic        s_mem_req_rdy[2];
  logic        s_mem_resp_val[2];
  logic        s_mem_resp_op[2];
  logic [15:0] s_mem_resp_addr[2];
  logic [15:0] s_mem_resp_data[2];
  logic [9:0]  s_mem_resp_opq[2];

  logic [2:0]  o_req_rdy[2];
  logic [2:0]  o_resp_val[2];
  logic        o_mem_req_val[2];
  logic        o_mem_req_op[2];
  logic        o_mem_resp_rdy[2];
  logic        o_resp_op[2];
  logic [15:0] o_mem_req_addr[2];
  logic [15:0] o_mem_req_data[2];
  logic [15:0] o_resp_addr[2];
  logic [15:0] o_resp_data[2];
  logic [9:0]  o_mem_req_opq[2];
  logic [7:0]  o_resp_opq[2];

  logic [1:0]  a_req_val, a_req_rdy, a_req_op, a_resp_val, a_resp_rdy;
  logic [31:0] a_req_addr, a_req_data;
  logic [15:0] a_req_opaque;
  logic        a_mem_req_val, a_mem_req_op, a_mem_resp_rdy, a_resp_op;
  logic [15:0] a_mem_req_addr, a_mem_req_data, a_resp_addr, a_resp_data;
  logic [8:0]  a_mem_req_opaque, a_mem_resp_opaque;
  logic [7:0]  a_resp_opaque;

  logic [2:0]  b_req_val, b_req_rdy, b_req_op, b_resp_val, b_resp_rdy;
  logic [47:0] b_req_addr, b_req_data;
  logic [23:0] b_req_opaque;
  logic        b_mem_req_val, b_mem_req_op, b_mem_resp_rdy, b_resp_op;
  logic [15:0] b_mem_req_addr, b_mem_req_data, b_resp_addr, b_resp_data;
  logic [9:0]  b_mem_req_opaque, b_mem_resp_opaque;
  logic [7:0]  b_resp_opaque;

`ifdef MEM_REQ_ARB_STATS_EN
  logic [63:0] a_stat_req;
  logic [95:0] b_stat_req;
  logic [31:0] a_stat_drop, b_stat_drop;
`endif

  assign a_req_val         = s_req_val[0][1:0];
  assign a_req_op          = s_req_op[0][1:0];
  assign a_resp_rdy        = s_resp_rdy[0][1:0];
  assign a_req_addr        = {s_addr[0][1], s_addr[0][0]};
  assign a_req_data        = {s_data[0][1], s_data[0][0]};
  assign a_req_opaque      = {s_opq[0][1], s_opq[0][0]};
  assign a_mem_resp_opaque = s_mem_resp_opq[0][8:0];
  assign b_req_val         = s_req_val[1];
  assign b_req_op          = s_req_op[1];
  assign b_resp_rdy        = s_resp_rdy[1];
  assign b_req_addr        = {s_addr[1][2], s_addr[1][1], s_addr[1][0]};
  assign b_req_data        = {s_data[1][2], s_data[1][1], s_data[1][0]};
  assign b_req_opaque      = {s_opq[1][2], s_opq[1][1], s_opq[1][0]};
  assign b_mem_resp_opaque = s_mem_resp_opq[1];

  assign o_req_rdy[0] = {1'b0, a_req_rdy};           assign o_req_rdy[1] = b_req_rdy;
  assign o_resp_val[0] = {1'b0, a_resp_val};         assign o_resp_val[1] = b_resp_val;
  assign o_mem_req_val[0] = a_mem_req_val;           assign o_mem_req_val[1] = b_mem_req_val;
  assign o_mem_req_op[0] = a_mem_req_op;             assign o_mem_req_op[1] = b_mem_req_op;
  assign o_mem_resp_rdy[0] = a_mem_resp_rdy;         assign o_mem_resp_rdy[1] = b_mem_resp_rdy;
  assign o_resp_op[0] = a_resp_op;                   assign o_resp_op[1] = b_resp_op;
  assign o_mem_req_addr[0] = a_mem_req_addr;         assign o_mem_req_addr[1] = b_mem_req_addr;
  assign o_mem_req_data[0] = a_mem_req_data;         assign o_mem_req_data[1] = b_mem_req_data;
  assign o_resp_addr[0] = a_resp_addr;               assign o_resp_addr[1] = b_resp_addr;
  assign o_resp_data[0] = a_resp_data;               assign o_resp_data[1] = b_resp_data;
  assign o_mem_req_opq[0] = {1'b0, a_mem_req_opaque}; assign o_mem_req_opq[1] = b_mem_req_opaque;
  assign o_resp_opq[0] = a_resp_opaque;              assign o_resp_opq[1] = b_resp_opaque;

  mem_req_arb_delay #(
    .p_num_ports(2), .p_opaq_bits(8), .p_addr_bits(16), .p_data_bits(16),
    .p_send_intv_delay(1), .p_recv_intv_delay(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .req_val(a_req_val), .req_rdy(a_req_rdy), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_data(a_req_data), .req_opaque(a_req_opaque),
    .mem_req_val(a_mem_req_val), .mem_req_rdy(s_mem_req_rdy[0]), .mem_req_op(a_mem_req_op),
    .mem_req_addr(a_mem_req_addr), .mem_req_data(a_mem_req_data), .mem_req_opaque(a_mem_req_opaque),
    .mem_resp_val(s_mem_resp_val[0]), .mem_resp_rdy(a_mem_resp_rdy), .mem_resp_op(s_mem_resp_op[0]),
    .mem_resp_addr(s_mem_resp_addr[0]), .mem_resp_data(s_mem_resp_data[0]),
    .mem_resp_opaque(a_mem_resp_opaque),
    .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_op(a_resp_op),
    .resp_addr(a_resp_addr), .resp_data(a_resp_data), .resp_opaque(a_resp_opaque)
`ifdef MEM_REQ_ARB_STATS_EN
    , .stat_req_count(a_stat_req), .stat_drop_count(a_stat_drop)
`endif
  );

  mem_req_arb_delay #(
    .p_num_ports(3), .p_opaq_bits(8), .p_addr_bits(16), .p_data_bits(16),
    .p_send_intv_delay(3), .p_recv_intv_delay(3)
  ) u_b (
    .clk(clk), .rst(rst),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_data(b_req_data), .req_opaque(b_req_opaque),
    .mem_req_val(b_mem_req_val), .mem_req_rdy(s_mem_req_rdy[1]), .mem_req_op(b_mem_req_op),
    .mem_req_addr(b_mem_req_addr), .mem_req_data(b_mem_req_data), .mem_req_opaque(b_mem_req_opaque),
    .mem_resp_val(s_mem_resp_val[1]), .mem_resp_rdy(b_mem_resp_rdy), .mem_resp_op(s_mem_resp_op[1]),
    .mem_resp_addr(s_mem_resp_addr[1]), .mem_resp_data(s_mem_resp_data[1]),
    .mem_resp_opaque(b_mem_resp_opaque),
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_op(b_resp_op),
    .resp_addr(b_resp_addr), .resp_data(b_resp_data), .resp_opaque(b_resp_opaque)
`ifdef MEM_REQ_ARB_STATS_EN
    , .stat_req_count(b_stat_req), .stat_drop_count(b_stat_drop)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending stalled port, cycles since last handshake on each path
  int       m_prio[2], m_gap_s[2], m_gap_r[2], m_lock[2];
  logic [2:0] m_acc[2];
  bit       m_resp_hs[2];
  int       m_stat_req[2][3];
  int       m_drop[2];

  function automatic int np(int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int dly(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prio[k] = 0; m_gap_s[k] = 100; m_gap_r[k] = 100; m_lock[k] = -1;
      m_acc[k] = 3'b000; m_resp_hs[k] = 1'b0; m_drop[k] = 0;
      for (int i = 0; i < 3; i++) m_stat_req[k][i] = 0;
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      s_req_val[k] = 3'b000; s_mem_req_rdy[k] = 1'b1; s_resp_rdy[k] = 3'b111;
      s_mem_resp_val[k] = 1'b0; s_mem_resp_opq[k] = 10'd0;
    end
  endtask

  // One cycle: compare both instances against the model, advance the model, move to next negedge
  task automatic tick();
    int n, g, id;
    bit any, rok, exp_mv, hs;
    logic [2:0] exp_rr, exp_rv;
    logic exp_mr;
    logic [9:0] exp_oq;
    #1;
    for (int k = 0; k < 2; k++) begin
      n = np(k);
      any = 1'b0;
      for (int i = 0; i < n; i++) if (s_req_val[k][i]) any = 1'b1;
      g = m_lock[k];
      if (g < 0) begin
        for (int j = 0; j < n; j++) if (g < 0 && s_req_val[k][(m_prio[k] + j) % n]) g = (m_prio[k] + j) % n;
      end
      exp_mv = any && (m_gap_s[k] >= dly(k));
      exp_rr = (exp_mv && s_mem_req_rdy[k]) ? (3'b001 << g) : 3'b000;
      checks++;
      if (o_mem_req_val[k] !== exp_mv) begin
        errors++; $display("FAIL mem_req_val inst%0d t=%0t got %b exp %b", k, $time, o_mem_req_val[k], exp_mv);
      end
      checks++;
      if (o_req_rdy[k] !== exp_rr) begin
        errors++; $display("FAIL req_rdy inst%0d t=%0t got %b exp %b", k, $time, o_req_rdy[k], exp_rr);
      end
      if (exp_mv) begin
        exp_oq = {g[1:0], s_opq[k][g]};
        checks++;
        if ({o_mem_req_opq[k], o_mem_req_op[k], o_mem_req_addr[k], o_mem_req_data[k]} !==
            {exp_oq, s_req_op[k][g], s_addr[k][g], s_data[k][g]}) begin
          errors++; $display("FAIL mem_req_payload inst%0d t=%0t got %h/%h exp %h/%h", k, $time,
                             o_mem_req_opq[k], o_mem_req_addr[k], exp_oq, s_addr[k][g]);
        end
      end
      id = int'(s_mem_resp_opq[k] >> 8);
      rok = (m_gap_r[k] >= dly(k));
      exp_rv = (s_mem_resp_val[k] && rok && id < n) ? (3'b001 << id) : 3'b000;
      exp_mr = rok && ((id >= n) || s_resp_rdy[k][id]);
      checks++;
      if (o_resp_val[k] !== exp_rv) begin
        errors++; $display("FAIL resp_val inst%0d t=%0t got %b exp %b", k, $time, o_resp_val[k], exp_rv);
      end
      checks++;
      if (o_mem_resp_rdy[k] !== exp_mr) begin
        errors++; $display("FAIL mem_resp_rdy inst%0d t=%0t got %b exp %b", k, $time, o_mem_resp_rdy[k], exp_mr);
      end
      checks++;
      if ({o_resp_op[k], o_resp_addr[k], o_resp_data[k], o_resp_opq[k]} !==
          {s_mem_resp_op[k], s_mem_resp_addr[k], s_mem_resp_data[k], s_mem_resp_opq[k][7:0]}) begin
        errors++; $display("FAIL resp_payload inst%0d t=%0t got %h exp %h", k, $time, o_resp_opq[k], s_mem_resp_opq[k][7:0]);
      end
      hs = exp_mv && s_mem_req_rdy[k];
      m_acc[k] = exp_rr;
      if (hs) begin
        m_prio[k] = (g + 1) % n; m_lock[k] = -1; m_gap_s[k] = 1; m_stat_req[k][g]++;
      end else begin
        if (exp_mv) m_lock[k] = g;
        if (m_gap_s[k] < 100) m_gap_s[k]++;
      end
      m_resp_hs[k] = s_mem_resp_val[k] && exp_mr;
      if (m_resp_hs[k]) begin
        m_gap_r[k] = 1;
        if (id >= n) m_drop[k]++;
      end else if (m_gap_r[k] < 100) begin
        m_gap_r[k]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    @(negedge clk);
    #1;
    checks++;
    if (o_mem_req_val[0] !== 1'b0 || o_mem_req_val[1] !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req_val got %b%b exp 00", o_mem_req_val[1], o_mem_req_val[0]);
    end
    checks++;
    if (o_resp_val[0] !== 3'b000 || o_resp_val[1] !== 3'b000) begin
      errors++; $display("FAIL reset_resp_val got %b/%b exp 000", o_resp_val[1], o_resp_val[0]);
    end
    checks++;
    if (o_mem_resp_rdy[0] !== 1'b1 || o_mem_resp_rdy[1] !== 1'b1) begin
      errors++; $display("FAIL reset_mem_resp_rdy got %b%b exp 11", o_mem_resp_rdy[1], o_mem_resp_rdy[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick(); tick();
  endtask

  task automatic test_rr_alternate();
    s_req_val[0] = 3'b011; s_mem_req_rdy[0] = 1'b1;
    s_opq[0][0] = 8'hA0; s_opq[0][1] = 8'hB1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (o_mem_req_opq[0] !== ((c % 2 == 0) ? 10'h0A0 : 10'h1B1)) begin
        errors++; $display("FAIL rr_opaque c=%0d got %h exp %h", c, o_mem_req_opq[0], (c % 2 == 0) ? 10'h0A0 : 10'h1B1);
      end
      checks++;
      if (o_req_rdy[0] !== ((c % 2 == 0) ? 3'b001 : 3'b010)) begin
        errors++; $display("FAIL rr_req_rdy c=%0d got %b", c, o_req_rdy[0]);
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_send_delay();
    tick(); tick(); tick();
    s_req_val[1] = 3'b001; s_mem_req_rdy[1] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++;
      if (o_mem_req_val[1] !== (c % 3 == 0)) begin
        errors++; $display("FAIL send_delay c=%0d got %b exp %b", c, o_mem_req_val[1], (c % 3 == 0));
      end
      tick();
    end
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_stall_hold();
    s_req_val[0] = 3'b010; s_mem_req_rdy[0] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) s_req_val[0][0] = 1'b1;
      if (c == 5) s_mem_req_rdy[0] = 1'b1;
      if (c == 6) s_req_val[0][1] = 1'b0;
      #1;
      checks++;
      if (o_mem_req_opq[0][8] !== ((c < 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL stall_grant c=%0d got %b exp %b", c, o_mem_req_opq[0][8], (c < 6));
      end
      checks++;
      if (o_req_rdy[0] !== ((c < 5) ? 3'b000 : ((c == 5) ? 3'b010 : 3'b001))) begin
        errors++; $display("FAIL stall_req_rdy c=%0d got %b", c, o_req_rdy[0]);
      end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_resp_route();
    logic [2:0] exp_rv[3];
    int ids[3];
    ids = '{2, 0, 3};
    exp_rv = '{3'b100, 3'b001, 3'b000};
    s_resp_rdy[1] = 3'b111;
    for (int c = 0; c < 3; c++) begin
      s_mem_resp_val[1] = 1'b1;
      s_mem_resp_opq[1] = 10'(ids[c] * 256 + 16 * c + 5);
      s_mem_resp_data[1] = 16'($urandom);
      #1;
      checks++;
      if (o_resp_val[1] !== exp_rv[c] || o_mem_resp_rdy[1] !== 1'b1) begin
        errors++; $display("FAIL resp_route id=%0d got val %b rdy %b exp val %b rdy 1", ids[c], o_resp_val[1], o_mem_resp_rdy[1], exp_rv[c]);
      end
      tick();
      s_mem_resp_val[1] = 1'b0;
      tick(); tick();
    end
`ifdef MEM_REQ_ARB_STATS_EN
    checks++;
    if (b_stat_drop !== 32'd1) begin
      errors++; $display("FAIL stat_drop_route got %0d exp 1", b_stat_drop);
    end
`endif
  endtask

  task automatic test_recv_delay();
    s_resp_rdy[1] = 3'b101;
    s_mem_resp_val[1] = 1'b1; s_mem_resp_opq[1] = 10'h177;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) s_resp_rdy[1] = 3'b111;
      if (c == 3) s_mem_resp_opq[1] = 10'h088;
      #1;
      checks++;
      if (o_mem_resp_rdy[1] !== (c == 2 || c == 5)) begin
        errors++; $display("FAIL recv_delay_rdy c=%0d got %b exp %b", c, o_mem_resp_rdy[1], (c == 2 || c == 5));
      end
      checks++;
      if (o_resp_val[1] !== ((c < 3) ? 3'b010 : ((c == 5) ? 3'b001 : 3'b000))) begin
        errors++; $display("FAIL recv_delay_val c=%0d got %b", c, o_resp_val[1]);
      end
      tick();
    end
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    s_req_val[1] = 3'b001; s_mem_req_rdy[1] = 1'b1;
    tick();
    s_req_val[1] = 3'b011;
    #1;
    checks++;
    if (o_mem_req_val[1] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pre got %b exp 0", o_mem_req_val[1]);
    end
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    checks++;
    if (o_mem_req_val[1] !== 1'b1 || o_mem_req_opq[1][9:8] !== 2'b00 || o_req_rdy[1] !== 3'b001) begin
      errors++; $display("FAIL reset_mid_post got val %b id %0d rdy %b exp 1 0 001", o_mem_req_val[1], o_mem_req_opq[1][9:8], o_req_rdy[1]);
    end
    tick();
    idle(); tick(); tick(); tick();
  endtask

  task automatic test_random();
    int id;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < np(k); i++) begin
          if (!s_req_val[k][i] || m_acc[k][i]) begin
            s_req_val[k][i] = ($urandom_range(0, 99) < 45);
            s_req_op[k][i]  = 1'($urandom_range(0, 1));
            s_addr[k][i]    = 16'($urandom);
            s_data[k][i]    = 16'($urandom);
            s_opq[k][i]     = 8'($urandom);
          end
        end
        s_mem_req_rdy[k] = ($urandom_range(0, 99) < 60);
        if (!s_mem_resp_val[k] || m_resp_hs[k]) begin
          s_mem_resp_val[k]  = ($urandom_range(0, 99) < 50);
          id = (k == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
          s_mem_resp_opq[k]  = 10'(id * 256 + $urandom_range(0, 255));
          s_mem_resp_op[k]   = 1'($urandom_range(0, 1));
          s_mem_resp_addr[k] = 16'($urandom);
          s_mem_resp_data[k] = 16'($urandom);
        end
        s_resp_rdy[k] = 3'($urandom_range(0, 7));
      end
      tick();
    end
`ifdef MEM_REQ_ARB_STATS_EN
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        checks++;
        if (a_stat_req[i*32 +: 32] !== 32'(m_stat_req[0][i])) begin
          errors++; $display("FAIL stat_req a port%0d got %0d exp %0d", i, a_stat_req[i*32 +: 32], m_stat_req[0][i]);
        end
      end
      checks++;
      if (b_stat_req[i*32 +: 32] !== 32'(m_stat_req[1][i])) begin
        errors++; $display("FAIL stat_req b port%0d got %0d exp %0d", i, b_stat_req[i*32 +: 32], m_stat_req[1][i]);
      end
    end
    checks++;
    if (b_stat_drop !== 32'(m_drop[1]) || a_stat_drop !== 32'(m_drop[0])) begin
      errors++; $display("FAIL stat_drop got %0d/%0d exp %0d/%0d", a_stat_drop, b_stat_drop, m_drop[0], m_drop[1]);
    end
`endif
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      s_req_op[k] = 3'b000; s_mem_resp_op[k] = 1'b0;
      s_mem_resp_addr[k] = 16'h1234; s_mem_resp_data[k] = 16'h5678;
      for (int i = 0; i < 3; i++) begin
        s_addr[k][i] = 16'($urandom); s_data[k][i] = 16'($urandom); s_opq[k][i] = 8'($urandom);
      end
    end
    model_reset();
    test_reset();
    test_rr_alternate();
    test_send_delay();
    test_stall_hold();
    test_resp_route();
    test_recv_delay();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
